// File: rtl/reflet_pkg.sv
// Shared constants for the Reflet register bank: fixed register indices and
// the stack-pointer operation encoding.
package reflet_pkg;
    localparam int WR_ID    = 0;
    localparam int SR_ID    = 1;
    localparam int PC_ID    = 2;
    localparam int SP_ID    = 3;
    localparam int GP_START = 4;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_INC  = 2'b01,
        SP_DEC  = 2'b10,
        SP_RSVD = 2'b11
    } sp_op_e;
endpackage

// File: rtl/reflet_regbank_if.sv
// Bus between the CPU top/execution units (master) and the register bank (slave):
// write-back sources, commit control, read ports and register views.
interface reflet_regbank_if #(
    parameter int wordsize = 16,
    parameter int nregs    = 16,
    parameter int nsrc     = 3
);
    localparam int iw = $clog2(nregs);

    logic [nsrc-1:0]          src_valid;
    logic [nsrc*iw-1:0]       src_index;
    logic [nsrc*wordsize-1:0] src_data;
    logic                     commit;
    logic [1:0]               sp_op;
    logic                     pc_step;
    logic                     irq_take;
    logic [wordsize-1:0]      irq_vector;
    logic                     halt_req;
    logic [iw-1:0]            rd_index_a;
    logic [iw-1:0]            rd_index_b;
    logic [wordsize-1:0]      rd_data_a;
    logic [wordsize-1:0]      rd_data_b;
    logic [wordsize-1:0]      wr_q;
    logic [wordsize-1:0]      sr_q;
    logic [wordsize-1:0]      pc_q;
    logic [wordsize-1:0]      sp_q;
    logic                     halted;
    logic                     conflict;

    modport master (
        output src_valid, src_index, src_data, commit, sp_op, pc_step,
               irq_take, irq_vector, halt_req, rd_index_a, rd_index_b,
        input  rd_data_a, rd_data_b, wr_q, sr_q, pc_q, sp_q, halted, conflict
    );

    modport slave (
        input  src_valid, src_index, src_data, commit, sp_op, pc_step,
               irq_take, irq_vector, halt_req, rd_index_a, rd_index_b,
        output rd_data_a, rd_data_b, wr_q, sr_q, pc_q, sp_q, halted, conflict
    );
endinterface

// File: rtl/reflet_wb_merge.sv
// Combinational nsrc-way write-back merge feeding the staging flops.
// With REFLET_REGBANK_CONFLICT_EN the lowest valid source wins and multi flags collisions.
module reflet_wb_merge #(
    parameter int wordsize = 16,
    parameter int iw       = 4,
    parameter int nsrc     = 3
) (
    input  logic [nsrc-1:0]          src_valid,
    input  logic [nsrc*iw-1:0]       src_index,
    input  logic [nsrc*wordsize-1:0] src_data,
    output logic                     m_valid,
    output logic [iw-1:0]            m_index,
    output logic [wordsize-1:0]      m_data,
    output logic                     multi
);
    always_comb begin
        m_valid = |src_valid;
        m_index = '0;
        m_data  = '0;
        multi   = 1'b0;
`ifdef REFLET_REGBANK_CONFLICT_EN
        multi = ($countones(src_valid) > 1);
        // Walk downwards so the lowest-numbered valid source is the last assignment.
        for (int k = nsrc - 1; k >= 0; k--) begin
            if (src_valid[k]) begin
                m_index = src_index[k*iw +: iw];
                m_data  = src_data[k*wordsize +: wordsize];
            end
        end
`else
        for (int k = 0; k < nsrc; k++) begin
            if (src_valid[k]) begin
                m_index = m_index | src_index[k*iw +: iw];
                m_data  = m_data  | src_data[k*wordsize +: wordsize];
            end
        end
`endif
    end
endmodule

// File: rtl/reflet_regbank.sv
// Reflet register bank: staged write-back, SP/PC/IRQ/halt handling under commit.
// Optional collision detection and priority merge via REFLET_REGBANK_CONFLICT_EN.
module reflet_regbank
    import reflet_pkg::*;
#(
    parameter int wordsize = 16,
    parameter int nregs    = 16,
    parameter int nsrc     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    reflet_regbank_if.slave  bus
);
    localparam int iw = $clog2(nregs);
    localparam logic [wordsize-1:0] SP_STEP = wordsize'(wordsize / 8);

    logic [wordsize-1:0] regs [nregs];
    logic                stage_valid;
    logic [iw-1:0]       stage_index;
    logic [wordsize-1:0] stage_data;
    logic                halted_q;
    logic                conflict_q;

    logic                m_valid;
    logic [iw-1:0]       m_index;
    logic [wordsize-1:0] m_data;
    logic                multi;
    logic                adv;
    logic [wordsize-1:0] sp_next;

    reflet_wb_merge #(.wordsize(wordsize), .iw(iw), .nsrc(nsrc)) u_merge (
        .src_valid (bus.src_valid),
        .src_index (bus.src_index),
        .src_data  (bus.src_data),
        .m_valid   (m_valid),
        .m_index   (m_index),
        .m_data    (m_data),
        .multi     (multi)
    );

    assign adv = enable && !halted_q;

    always_comb begin
        sp_next = regs[SP_ID];
        case (bus.sp_op)
            SP_INC:  sp_next = regs[SP_ID] + SP_STEP;
            SP_DEC:  sp_next = regs[SP_ID] - SP_STEP;
            default: sp_next = regs[SP_ID];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < nregs; i++) regs[i] <= '0;
            stage_valid <= 1'b0;
            stage_index <= '0;
            stage_data  <= '0;
            halted_q    <= 1'b0;
            conflict_q  <= 1'b0;
        end else if (adv) begin
            stage_valid <= m_valid;
            stage_index <= m_index;
            stage_data  <= m_data;
            conflict_q  <= conflict_q | multi;
            if (bus.commit) begin
                if (bus.irq_take) begin
                    regs[PC_ID] <= bus.irq_vector;
                end else begin
                    regs[SP_ID] <= sp_next;
                    // Later assignment lets a staged write to sp override sp_op.
                    if (stage_valid) regs[stage_index] <= stage_data;
                    if (bus.halt_req) halted_q <= 1'b1;
                end
            end else if (bus.pc_step) begin
                regs[PC_ID] <= regs[PC_ID] + 1'b1;
            end
        end
    end

    assign bus.rd_data_a = regs[bus.rd_index_a];
    assign bus.rd_data_b = regs[bus.rd_index_b];
    assign bus.wr_q      = regs[WR_ID];
    assign bus.sr_q      = regs[SR_ID];
    assign bus.pc_q      = regs[PC_ID];
    assign bus.sp_q      = regs[SP_ID];
    assign bus.halted    = halted_q;
    assign bus.conflict  = conflict_q;
endmodule

// File: doc/reflet_regbank.md
# reflet_regbank

Parametrised register bank and write-back arbiter for the Reflet CPU core. It holds the architectural registers and accepts write-back from `nsrc` execution units (ALU, address/memory unit, interrupt controller, …) through a registered merge stage. It applies stack-pointer adjustment, program-counter stepping, interrupt vectoring and the halt latch under commit control. It sits between the execution units and the CPU top and supersedes the fixed 16-register, three-source register logic in earlier cores.

## Interface
- `wordsize`, 16: register width in bits; multiple of 8, ≥ 8.
- `nregs`, 16: number of registers; power of two, 4..64; index width `iw = $clog2(nregs)`.
- `nsrc`, 3: number of write-back sources, 1..8.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: global advance; when low, all state holds.
- `src_valid` in `nsrc`: per-source write request this cycle.
- `src_index` in `nsrc*iw`: packed target indices; source k occupies bits `[k*iw +: iw]`.
- `src_data` in `nsrc*wordsize`: packed write data, packed the same way.
- `commit` in 1: retire the current instruction and apply the staged write.
- `sp_op` in 2: 00 none, 01 `sp += wordsize/8`, 10 `sp -= wordsize/8`, 11 reserved (treated as none).
- `pc_step` in 1: `pc += 1`; honoured only when `commit` is low.
- `irq_take` in 1: with `commit`, load `pc` from `irq_vector` instead of retiring.
- `irq_vector` in `wordsize`: interrupt routine address.
- `halt_req` in 1: with `commit`, set `halted`.
- `rd_index_a`, `rd_index_b` in `iw`: combinational read port indices.
- `rd_data_a`, `rd_data_b` out `wordsize`: register contents at those indices.
- `wr_q`, `sr_q`, `pc_q`, `sp_q` out `wordsize`: dedicated register views.
- `halted` out 1: sticky halt flag.
- `conflict` out 1: multiple-source write detected (`REFLET_REGBANK_CONFLICT_EN` only; otherwise tied 0).

## Operation
- Fixed indices: wr = 0, sr = 1, pc = 2, sp = 3; indices 4..`nregs-1` are general purpose.
- Staging: on every cycle with `enable && !halted`, capture `stage_valid = |src_valid`, `stage_index = OR of src_index[k]` over valid k, and `stage_data = OR of src_data[k]` over valid k. Invalid sources contribute zero.
- Commit, evaluated on cycles with `enable && !halted && commit`, in priority order:
  1. If `irq_take`: `pc <= irq_vector`. Staged write, `sp_op` and `halt_req` are ignored.
  2. Otherwise: apply `sp_op` to sp; then, if `stage_valid`, `reg[stage_index] <= stage_data`. A staged write to sp overrides `sp_op`. If `halt_req`, set `halted`.
- When `commit` is low and `pc_step` is high, `pc <= pc + 1`, modulo 2^wordsize.
- SP arithmetic is modulo 2^wordsize; wraps silently in both directions.
- Once set, `halted` freezes all registers and staging until reset.
- Reads are combinational from current register state; there is no write-to-read bypass.

## Timing
- Reset: all registers 0, staging 0, `halted` 0, `conflict` 0. All outputs therefore read 0.
- Source write to architectural update: 2 cycles. Data is staged at edge N; it is visible at edge N+1 only if `commit` is high in cycle N+1.
- Staging is overwritten every enabled cycle. A staged write not committed in the next cycle is lost; callers hold `src_valid` until commit.
- `irq_vector` is sampled in the commit cycle; `pc_q` shows it after that edge.
- Reset asserted mid-operation clears everything immediately, including a pending staged write.

## Configuration
- `REFLET_REGBANK_CONFLICT_EN` defined: in the stage cycle, if two or more `src_valid` bits are set, `conflict` is set sticky at the next edge. The lowest-numbered valid source is staged alone instead of the OR merge.
- Undefined: OR merge with no detection; `conflict` is constant 0.

## Structure
- Package `reflet_pkg`: register index constants (`WR_ID`, `SR_ID`, `PC_ID`, `SP_ID`, `GP_START`) and the `sp_op` encoding constants.
- One sub-module, `reflet_wb_merge`: combinational `nsrc`-way merge, including the optional conflict/priority logic, feeding the staging flops.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs 0 before the next edge, `halted` = 0.
- Write path: source 1 writes idx 5 = 0xBEEF, then commit the next cycle -> `rd_data_a` (idx 5) = 0xBEEF after the second edge. Without commit -> stays 0.
- Stack: sp = 0x0000, commit with `sp_op` = 10 -> `sp_q` = 0xFFFE. Then `sp_op` = 01 with a staged write to sp of 0x1234 -> `sp_q` = 0x1234.
- Interrupt priority: staged write to wr = 7, commit with `irq_take` and `irq_vector` = 0x0100 -> `pc_q` = 0x0100 and wr unchanged.
- PC step and halt: `pc_step` 3 cycles -> `pc_q` = 3. Commit with `halt_req` -> `halted` = 1; further `pc_step` and commits leave `pc_q` = 3.
- Conflict (macro on): sources 0 and 2 both valid with idx 4 / 0x00F0 and idx 6 / 0x000F -> `conflict` = 1, and only idx 4 = 0x00F0 is written after commit. With the macro off -> idx 6 = 0x00FF, `conflict` = 0.
